// File: rtl/fc_score_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fc_score_packer_if
//  Description : Bundle of the score stream, packed-frame and status signals
//                between the FC output layer, the packer and the argmax stage.
//                master = producer/consumer side, slave = packer side.
//  Signals     : in_valid/in_data/in_last/in_ready  score beat stream
//                out_data/out_valid/out_ack          packed frame to argmax
//                err_len                             frame-length error pulse
//                frame_cnt                           delivered frame counter
//  Revision    : 1.0 - initial release
// ============================================================================
interface fc_score_packer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10
);
  localparam int OUT_WIDTH = DATA_WIDTH * NUM_CLASSES;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ack;
  logic                  err_len;
  logic [15:0]           frame_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ack,
    input  in_ready, out_data, out_valid, err_len, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ack,
    output in_ready, out_data, out_valid, err_len, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fc_score_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fc_score_packer
//  Description : Collects NUM_CLASSES unsigned scores streamed one per beat,
//                packs them into one flat vector (class 0 in the LSBs) and
//                holds it with a level valid until the argmax stage acks.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - fc_score_packer_if.slave (stream in, frame out,
//                         err_len pulse, 16-bit delivered-frame counter)
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_score_packer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  fc_score_packer_if.slave  bus
);

  localparam int OUT_WIDTH = DATA_WIDTH * NUM_CLASSES;
  localparam int IDX_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 r_out_valid;
  logic                 w_out_valid_nxt;
  logic                 r_err_len;
  logic                 w_err_len_nxt;
  logic [15:0]          r_frame_cnt;
  logic                 w_cnt_inc;
  logic                 w_slot_we;
  logic                 w_accept;
  logic                 w_last_slot;
  logic [OUT_WIDTH-1:0] w_packed;

  // Ready is a pure state decode so the consumer's ack never combinationally
  // reaches the producer; the price is one bubble after every ack.
  assign w_accept    = bus.in_valid && (r_state != S_HOLD);
  assign w_last_slot = (r_idx == c_LAST_IDX);

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_out_valid_nxt = r_out_valid;
    w_err_len_nxt   = 1'b0;
    w_cnt_inc       = 1'b0;
    w_slot_we       = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_accept) begin
          if (w_last_slot) begin
            // Final slot completes the frame whether or not in_last came
            // with it; a missing in_last is flagged alongside the valid rise.
            w_slot_we       = 1'b1;
            w_idx_nxt       = '0;
            w_state_nxt     = S_HOLD;
            w_out_valid_nxt = 1'b1;
            w_cnt_inc       = 1'b1;
            w_err_len_nxt   = ~bus.in_last;
          end else if (bus.in_last) begin
            // Short frame: drop it. Stale slots are harmless because the
            // next frame overwrites every slot before it is presented.
            w_idx_nxt     = '0;
            w_state_nxt   = S_IDLE;
            w_err_len_nxt = 1'b1;
          end else begin
            w_slot_we   = 1'b1;
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_COLLECT;
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ack) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_idx_nxt       = '0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_err_len   <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_err_len   <= w_err_len_nxt;
      if (w_cnt_inc) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // One register per class slot; slots only load on accepted beats, so the
  // packed vector is frozen for the whole HOLD phase.
  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_slot <= '0;
      end else if (w_slot_we && (r_idx == IDX_W'(k))) begin
        r_slot <= bus.in_data;
      end
    end

    assign w_packed[k*DATA_WIDTH +: DATA_WIDTH] = r_slot;
  end

  assign bus.in_ready  = (r_state != S_HOLD);
  assign bus.out_data  = w_packed;
  assign bus.out_valid = r_out_valid;
  assign bus.err_len   = r_err_len;
  assign bus.frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fc_score_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_score_packer
//  Description : Self-checking bench for fc_score_packer. Frame vectors come
//                from a table; expected frames go into a scoreboard queue and
//                are popped on each rising edge of out_valid. Hand-written
//                sequences cover back-pressure, reset, counter wrap and the
//                single-class configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_score_packer;

  localparam int c_DW  = 32;
  localparam int c_NC  = 10;
  localparam int c_OW  = c_DW * c_NC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_score_packer_if #(.DATA_WIDTH(c_DW), .NUM_CLASSES(c_NC)) bus ();
  fc_score_packer_if #(.DATA_WIDTH(c_DW), .NUM_CLASSES(1))    bus1 ();

  fc_score_packer #(.DATA_WIDTH(c_DW), .NUM_CLASSES(c_NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fc_score_packer #(.DATA_WIDTH(c_DW), .NUM_CLASSES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    logic [c_OW-1:0] data;
    logic [15:0]     cnt;
    logic            err;
  } exp_t;

  typedef struct {
    int          nb;
    bit          last_on_final;
    int          gap;
    logic [31:0] base;
    bit          deliver;
    bit          err;
  } vec_t;

  exp_t            sbq[$];
  int              n_assert      = 0;
  int              n_fail        = 0;
  int              rise_cnt      = 0;
  int              early_err_cnt = 0;
  int              run_len       = 0;
  int              last_run      = 0;
  logic            prev_v        = 1'b0;
  logic            prev_e        = 1'b0;
  logic [c_OW-1:0] held;
  logic [15:0]     exp_cnt       = 16'd0;

  task automatic chk(input string nm, input logic [c_OW-1:0] act, input logic [c_OW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [c_OW-1:0] mk_frame(input logic [31:0] base);
    logic [c_OW-1:0] v;
    v = '0;
    for (int k = 0; k < c_NC; k++) v[k*c_DW +: c_DW] = base + 32'(k);
    return v;
  endfunction

  task automatic push_exp(input logic [31:0] base, input logic err);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.data  = mk_frame(base);
    e.cnt   = exp_cnt;
    e.err   = err;
    sbq.push_back(e);
  endtask

  // Monitor: scoreboard pop on out_valid rise, stability while held,
  // err_len pulse classification.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_e  = 1'b0;
      run_len = 0;
    end else begin
      if (bus.out_valid && !prev_v) begin
        rise_cnt++;
        run_len = 1;
        held    = bus.out_data;
        if (sbq.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("frame_data", bus.out_data, e.data);
          chk("frame_cnt", c_OW'(bus.frame_cnt), c_OW'(e.cnt));
          chk("err_with_valid", c_OW'(bus.err_len), c_OW'(e.err));
        end
      end else if (bus.out_valid) begin
        run_len++;
        chk("hold_stable", bus.out_data, held);
      end else if (prev_v) begin
        last_run = run_len;
      end
      if (bus.err_len && !(bus.out_valid && !prev_v)) early_err_cnt++;
      if (bus.err_len && prev_e) chk("err_pulse_len", 1, 0);
      prev_v = bus.out_valid;
      prev_e = bus.err_len;
    end
  end

  // Called right after a negedge; returns right after the negedge that
  // follows the accepting posedge.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("beat_accept_timeout", 1, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int nb, input bit last_on_final, input int gap, input logic [31:0] base);
    for (int k = 0; k < nb; k++) begin
      send_beat(base + 32'(k), last_on_final && (k == nb - 1));
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_delivery(input int rise0);
    int t;
    t = 0;
    while (rise_cnt == rise0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("delivery_seen", c_OW'(rise_cnt), c_OW'(rise0 + 1));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t tbl[8];
    int   rise0;
    int   err0;
    int   t;

    tbl[0] = '{10, 1'b1, 0, 32'h0000_0001, 1'b1, 1'b0};
    tbl[1] = '{10, 1'b0, 0, 32'h0000_0100, 1'b1, 1'b1};
    tbl[2] = '{10, 1'b0, 1, 32'h0000_0100, 1'b1, 1'b1};
    tbl[3] = '{10, 1'b0, 2, 32'h0000_0100, 1'b1, 1'b1};
    tbl[4] = '{10, 1'b0, 3, 32'h0000_0100, 1'b1, 1'b1};
    tbl[5] = '{ 6, 1'b1, 0, 32'hAAAA_0000, 1'b0, 1'b1};
    tbl[6] = '{10, 1'b1, 0, 32'hFFFF_FFF0, 1'b1, 1'b0};
    tbl[7] = '{10, 1'b1, 2, 32'h1234_5678, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ack   = 1'b1;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    bus1.in_last  = 1'b0;
    bus1.out_ack  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", c_OW'(bus.out_valid), 0);
    chk("rst_in_ready", c_OW'(bus.in_ready), 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_frame_cnt", c_OW'(bus.frame_cnt), 0);
    chk("rst_err_len", c_OW'(bus.err_len), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      rise0 = rise_cnt;
      err0  = early_err_cnt;
      if (tbl[i].deliver) push_exp(tbl[i].base, tbl[i].err);
      send_frame(tbl[i].nb, tbl[i].last_on_final, tbl[i].gap, tbl[i].base);
      if (tbl[i].deliver) begin
        wait_delivery(rise0);
        repeat (3) @(negedge clk);
        chk("valid_one_cycle", c_OW'(last_run), 1);
        chk("no_stray_err", c_OW'(early_err_cnt), c_OW'(err0));
      end else begin
        repeat (4) @(negedge clk);
        chk("early_no_valid", c_OW'(rise_cnt), c_OW'(rise0));
        chk("early_err_pulse", c_OW'(early_err_cnt), c_OW'(err0 + 1));
        chk("early_cnt_same", c_OW'(bus.frame_cnt), c_OW'(exp_cnt));
      end
    end

    // Back-pressure: hold without ack while the producer keeps pushing
    bus.out_ack = 1'b0;
    rise0 = rise_cnt;
    push_exp(32'h0000_0200, 1'b0);
    send_frame(10, 1'b1, 0, 32'h0000_0200);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_in_ready", c_OW'(bus.in_ready), 0);
      chk("bp_out_valid", c_OW'(bus.out_valid), 1);
    end
    chk("bp_single_rise", c_OW'(rise_cnt), c_OW'(rise0 + 1));
    bus.in_valid = 1'b0;
    bus.out_ack  = 1'b1;
    @(negedge clk);
    chk("ack_valid_low", c_OW'(bus.out_valid), 0);
    chk("ack_ready_back", c_OW'(bus.in_ready), 1);
    rise0 = rise_cnt;
    push_exp(32'h0000_0300, 1'b0);
    send_frame(10, 1'b1, 0, 32'h0000_0300);
    wait_delivery(rise0);

    // Reset mid-collect with 4 slots filled
    repeat (2) @(negedge clk);
    send_frame(4, 1'b0, 0, 32'h0000_0400);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", c_OW'(bus.out_valid), 0);
    chk("midrst_in_ready", c_OW'(bus.in_ready), 1);
    chk("midrst_frame_cnt", c_OW'(bus.frame_cnt), 0);
    chk("midrst_out_data", bus.out_data, 0);
    rst_n   = 1'b1;
    exp_cnt = 16'd0;
    @(negedge clk);
    rise0 = rise_cnt;
    push_exp(32'h0000_0500, 1'b0);
    send_frame(10, 1'b1, 0, 32'h0000_0500);
    wait_delivery(rise0);

    // Counter wrap: jump the counter to its top value
    repeat (3) @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    @(negedge clk);
    exp_cnt = 16'hFFFF;
    rise0 = rise_cnt;
    push_exp(32'h0000_0600, 1'b0);
    send_frame(10, 1'b1, 0, 32'h0000_0600);
    wait_delivery(rise0);
    repeat (2) @(negedge clk);
    chk("wrap_cnt_zero", c_OW'(bus.frame_cnt), 0);

    // Single-class configuration: every accepted beat is a frame
    for (int i = 0; i < 3; i++) begin
      t = 0;
      bus1.in_valid = 1'b1;
      bus1.in_data  = 32'hC0DE_0000 + 32'(i);
      bus1.in_last  = (i != 2);
      while (!bus1.in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      bus1.in_valid = 1'b0;
      chk("nc1_valid", c_OW'(bus1.out_valid), 1);
      chk("nc1_data", c_OW'(bus1.out_data), c_OW'(32'hC0DE_0000 + 32'(i)));
      chk("nc1_cnt", c_OW'(bus1.frame_cnt), c_OW'(i + 1));
      chk("nc1_err", c_OW'(bus1.err_len), c_OW'(i == 2));
    end

    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_empty", c_OW'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
